// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: sequencer states, opcodes, ir field positions.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC1 = 2'd1,
        EXEC2 = 2'd2
    } state_e;

    localparam logic [1:0] OP_ALU = 2'b11;
    localparam logic [1:0] OP_JMP = 2'b10;
    localparam logic [1:0] OP_LDR = 2'b00;
    localparam logic [1:0] OP_STR = 2'b01;

    // Opcode field of ir.
    localparam int unsigned IR_OP_MSB = 15;
    localparam int unsigned IR_OP_LSB = 14;

endpackage

// File: rtl/status_flags.sv
// CARRY and SKIP status flip-flops with individual enables and a skip-clear input.
// Skip-clear takes priority over the skip enable.
module status_flags (
    input  logic clk,
    input  logic rst_n,
    input  logic carryin,
    input  logic carryen,
    input  logic skipin,
    input  logic skipen,
    input  logic skipclr,
    output logic carrystatus,
    output logic skipstatus
);

    logic carry_q, carry_d;
    logic skip_q, skip_d;

    // Next-state for both flags.
    always_comb begin
        carry_d = carry_q;
        skip_d  = skip_q;
        if (carryen) begin
            carry_d = carryin;
        end
        if (skipclr) begin
            skip_d = 1'b0;
        end else if (skipen) begin
            skip_d = skipin;
        end
    end

    // Flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            carry_q <= carry_d;
            skip_q  <= skip_d;
        end
    end

    assign carrystatus = carry_q;
    assign skipstatus  = skip_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer for the 16-bit CPU. Owns pc, ir, lddata and the status flags,
// and runs the FETCH/EXEC1/EXEC2 timing. Handles LDR, STR and JMP itself; ALU work is
// done outside and only its flag updates come back here.
// Optional build macro INSTR_COUNT_EN adds the retired-instruction counter output.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       mem_wdata,
    output logic              mem_wen,
    output logic [15:0]       ir,
    output logic              exec1,
    output logic              exec2,
    output logic              ldwen,
    output logic [15:0]       lddata,
    input  logic [15:0]       rddata,
    input  logic [15:0]       rsdata,
    input  logic              carryin,
    input  logic              carryen,
    input  logic              skipin,
    input  logic              skipen,
    output logic              carrystatus,
    output logic              skipstatus,
`ifdef INSTR_COUNT_EN
    output logic [31:0]       retired,
`endif
    output logic [ADDR_W-1:0] pc
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [15:0]       lddata_q, lddata_d;
    logic              flag_carryen;
    logic              flag_skipen;
    logic              skip_clr;
    logic              retire;
    logic [1:0]        op;

    // Only the low ADDR_W bits of Rs form an address.
    logic unused_rs;
    assign unused_rs = ^rsdata;

    assign op = ir_q[IR_OP_MSB:IR_OP_LSB];

    // Sequencer next-state, datapath updates and strobes.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        lddata_d     = lddata_q;
        mem_addr     = pc_q;
        mem_wen      = 1'b0;
        exec1        = 1'b0;
        exec2        = 1'b0;
        ldwen        = 1'b0;
        flag_carryen = 1'b0;
        flag_skipen  = 1'b0;
        skip_clr     = 1'b0;
        retire       = 1'b0;
        unique case (state_q)
            FETCH: begin
                ir_d = mem_rdata;
                pc_d = pc_q + ADDR_W'(1);
                // A pending skip discards the freshly fetched instruction.
                if (skipstatus) begin
                    skip_clr = 1'b1;
                    state_d  = FETCH;
                end else begin
                    state_d = EXEC1;
                end
            end
            EXEC1: begin
                exec1   = 1'b1;
                state_d = FETCH;
                unique case (op)
                    OP_ALU: begin
                        flag_carryen = carryen;
                        flag_skipen  = skipen;
                        retire       = 1'b1;
                    end
                    OP_JMP: begin
                        pc_d   = ir_q[ADDR_W-1:0];
                        retire = 1'b1;
                    end
                    OP_STR: begin
                        mem_addr = rsdata[ADDR_W-1:0];
                        mem_wen  = 1'b1;
                        retire   = 1'b1;
                    end
                    OP_LDR: begin
                        mem_addr = rsdata[ADDR_W-1:0];
                        lddata_d = mem_rdata;
                        state_d  = EXEC2;
                    end
                endcase
            end
            EXEC2: begin
                exec2   = 1'b1;
                ldwen   = 1'b1;
                retire  = 1'b1;
                state_d = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Sequencer state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= ADDR_W'(RESET_PC);
            ir_q     <= '0;
            lddata_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            lddata_q <= lddata_d;
        end
    end

    status_flags u_status_flags (
        .clk         (clk),
        .rst_n       (rst_n),
        .carryin     (carryin),
        .carryen     (flag_carryen),
        .skipin      (skipin),
        .skipen      (flag_skipen),
        .skipclr     (skip_clr),
        .carrystatus (carrystatus),
        .skipstatus  (skipstatus)
    );

`ifdef INSTR_COUNT_EN
    logic [31:0] retired_q, retired_d;

    // Count instructions on their final execute cycle; skipped ones never get there.
    always_comb begin
        retired_d = retired_q;
        if (retire) begin
            retired_d = retired_q + 32'd1;
        end
    end

    // Retired-instruction counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

    assign mem_wdata = rddata;
    assign ir        = ir_q;
    assign lddata    = lddata_q;
    assign pc        = pc_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: table of single instructions run back to back
// through a scoreboard queue, plus hand-written reset and skip corner cases.
module tb_cpu_sequencer;

    localparam int unsigned ADDR_W = 8;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_rdata;
    logic [15:0]       mem_wdata;
    logic              mem_wen;
    logic [15:0]       ir;
    logic              exec1;
    logic              exec2;
    logic              ldwen;
    logic [15:0]       lddata;
    logic [15:0]       rddata;
    logic [15:0]       rsdata;
    logic              carryin;
    logic              carryen;
    logic              skipin;
    logic              skipen;
    logic              carrystatus;
    logic              skipstatus;
    logic [ADDR_W-1:0] pc;
`ifdef INSTR_COUNT_EN
    logic [31:0]       retired;
`endif

    logic [15:0] mem [256];
    assign mem_rdata = mem[mem_addr];

    cpu_sequencer #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_wdata   (mem_wdata),
        .mem_wen     (mem_wen),
        .ir          (ir),
        .exec1       (exec1),
        .exec2       (exec2),
        .ldwen       (ldwen),
        .lddata      (lddata),
        .rddata      (rddata),
        .rsdata      (rsdata),
        .carryin     (carryin),
        .carryen     (carryen),
        .skipin      (skipin),
        .skipen      (skipen),
        .carrystatus (carrystatus),
        .skipstatus  (skipstatus),
`ifdef INSTR_COUNT_EN
        .retired     (retired),
`endif
        .pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [7:0]  rs;
        logic [15:0] rd;
        logic        cin, cen, sin, sen;
        logic [15:0] ldval;
        int          cycles;
        int          n_exec1, n_exec2, n_wen;
        logic [7:0]  pc_after;
        logic        carry, skip;
        logic [7:0]  waddr;
        logic [15:0] wdata;
        logic [15:0] lddata;
    } vec_t;

    vec_t vecs [13];
    vec_t exp_q [$];
    int   n_cmp;
    int   n_fail;
    int   n_exec_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Run one instruction at the current pc; sampled 1ns after each rising edge.
    task automatic run_vec(input int idx, input vec_t v, input logic [7:0] at_pc);
        int         c1, c2, cl, cw;
        logic [7:0] wa;
        logic [15:0] wd;
        vec_t       e;
        c1 = 0; c2 = 0; cl = 0; cw = 0; wa = 8'h00; wd = 16'h0000;
        mem[at_pc] = v.instr;
        if (v.instr[15:14] == 2'b00) mem[v.rs] = v.ldval;
        rsdata  = {8'h00, v.rs};
        rddata  = v.rd;
        carryin = v.cin;
        carryen = v.cen;
        skipin  = v.sin;
        skipen  = v.sen;
        exp_q.push_back(v);
        for (int c = 0; c < v.cycles; c++) begin
            if (exec1) c1++;
            if (exec2) c2++;
            if (ldwen) cl++;
            if (mem_wen) begin
                cw++;
                wa = mem_addr;
                wd = mem_wdata;
            end
            @(posedge clk);
            #1;
        end
        e = exp_q.pop_front();
        check($sformatf("v%0d exec1_count", idx), c1, e.n_exec1);
        check($sformatf("v%0d exec2_count", idx), c2, e.n_exec2);
        check($sformatf("v%0d ldwen_count", idx), cl, e.n_exec2);
        check($sformatf("v%0d wen_count", idx), cw, e.n_wen);
        if (e.n_wen != 0) begin
            check($sformatf("v%0d store_addr", idx), {24'h0, wa}, {24'h0, e.waddr});
            check($sformatf("v%0d store_data", idx), {16'h0, wd}, {16'h0, e.wdata});
        end
        check($sformatf("v%0d ir", idx), {16'h0, ir}, {16'h0, e.instr});
        check($sformatf("v%0d pc", idx), {24'h0, pc}, {24'h0, e.pc_after});
        check($sformatf("v%0d fetch_addr", idx), {24'h0, mem_addr}, {24'h0, e.pc_after});
        check($sformatf("v%0d exec1_idle", idx), {31'h0, exec1}, 32'h0);
        check($sformatf("v%0d carry", idx), {31'h0, carrystatus}, {31'h0, e.carry});
        check($sformatf("v%0d skip", idx), {31'h0, skipstatus}, {31'h0, e.skip});
        check($sformatf("v%0d lddata", idx), {16'h0, lddata}, {16'h0, e.lddata});
        n_exec_total += e.n_exec1;
    endtask

    function automatic vec_t mk(input logic [15:0] instr, input logic [7:0] rs,
                                input logic [15:0] rd, input logic [3:0] flags,
                                input logic [15:0] ldval, input int cycles,
                                input int n1, input int n2, input int nw,
                                input logic [7:0] pc_after, input logic carry,
                                input logic skip, input logic [15:0] ld);
        vec_t v;
        v.instr = instr; v.rs = rs; v.rd = rd;
        v.cin = flags[3]; v.cen = flags[2]; v.sin = flags[1]; v.sen = flags[0];
        v.ldval = ldval; v.cycles = cycles;
        v.n_exec1 = n1; v.n_exec2 = n2; v.n_wen = nw;
        v.pc_after = pc_after; v.carry = carry; v.skip = skip;
        v.waddr = rs; v.wdata = rd; v.lddata = ld;
        return v;
    endfunction

    initial begin
        logic [7:0] cur_pc;
        n_cmp = 0; n_fail = 0; n_exec_total = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        rst_n = 1'b0; rddata = '0; rsdata = '0;
        carryin = 1'b0; carryen = 1'b0; skipin = 1'b0; skipen = 1'b0;

        // flags = {cin, cen, sin, sen}
        vecs[0]  = mk(16'hC000, 8'h00, 16'h0000, 4'b1100, 16'h0000, 2, 1, 0, 0, 8'h01, 1, 0, 16'h0000);
        vecs[1]  = mk(16'h8005, 8'h00, 16'h0000, 4'b0111, 16'h0000, 2, 1, 0, 0, 8'h05, 1, 0, 16'h0000);
        vecs[2]  = mk(16'h0300, 8'h20, 16'h0000, 4'b0100, 16'hBEEF, 3, 1, 1, 0, 8'h06, 1, 0, 16'hBEEF);
        vecs[3]  = mk(16'h4100, 8'h30, 16'h1234, 4'b0000, 16'h0000, 2, 1, 0, 1, 8'h07, 1, 0, 16'hBEEF);
        vecs[4]  = mk(16'hC100, 8'h00, 16'h0000, 4'b0111, 16'h0000, 2, 1, 0, 0, 8'h08, 0, 1, 16'hBEEF);
        vecs[5]  = mk(16'h4200, 8'h31, 16'h5555, 4'b1111, 16'h0000, 1, 0, 0, 0, 8'h09, 0, 0, 16'hBEEF);
        vecs[6]  = mk(16'hC200, 8'h00, 16'h0000, 4'b1000, 16'h0000, 2, 1, 0, 0, 8'h0A, 0, 0, 16'hBEEF);
        vecs[7]  = mk(16'h800A, 8'h00, 16'h0000, 4'b0000, 16'h0000, 2, 1, 0, 0, 8'h0A, 0, 0, 16'hBEEF);
        vecs[8]  = mk(16'h80FF, 8'h00, 16'h0000, 4'b0000, 16'h0000, 2, 1, 0, 0, 8'hFF, 0, 0, 16'hBEEF);
        vecs[9]  = mk(16'hC300, 8'h00, 16'h0000, 4'b1100, 16'h0000, 2, 1, 0, 0, 8'h00, 1, 0, 16'hBEEF);
        vecs[10] = mk(16'hC400, 8'h00, 16'h0000, 4'b0011, 16'h0000, 2, 1, 0, 0, 8'h01, 1, 1, 16'hBEEF);
        vecs[11] = mk(16'h0500, 8'h21, 16'h0000, 4'b0000, 16'h7777, 1, 0, 0, 0, 8'h02, 1, 0, 16'hBEEF);
        vecs[12] = mk(16'hC500, 8'h00, 16'h0000, 4'b1101, 16'h0000, 2, 1, 0, 0, 8'h03, 1, 0, 16'hBEEF);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst pc", {24'h0, pc}, 32'h0);
        check("rst ir", {16'h0, ir}, 32'h0);
        check("rst lddata", {16'h0, lddata}, 32'h0);
        check("rst flags", {30'h0, carrystatus, skipstatus}, 32'h0);
        check("rst strobes", {28'h0, exec1, exec2, mem_wen, ldwen}, 32'h0);
        rst_n = 1'b1;

        cur_pc = 8'h00;
        for (int i = 0; i < 13; i++) begin
            run_vec(i, vecs[i], cur_pc);
            cur_pc = vecs[i].pc_after;
        end

`ifdef INSTR_COUNT_EN
        check("retired", retired, n_exec_total);
`endif

        // Reset during EXEC1 of an LDR aborts it.
        mem[cur_pc] = 16'h0600;
        mem[8'h22]  = 16'hAAAA;
        rsdata = 16'h0022;
        carryin = 1'b0; carryen = 1'b0; skipin = 1'b0; skipen = 1'b0;
        @(posedge clk);
        #1;
        check("midldr exec1", {31'h0, exec1}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("midldr pc", {24'h0, pc}, 32'h0);
        check("midldr strobes", {28'h0, exec1, exec2, mem_wen, ldwen}, 32'h0);
        check("midldr flags", {30'h0, carrystatus, skipstatus}, 32'h0);
        check("midldr lddata", {16'h0, lddata}, 32'h0);
        @(posedge clk);
        #1;
        check("midldr ldwen", {30'h0, ldwen, exec2}, 32'h0);
        rst_n = 1'b1;
        run_vec(13, mk(16'hC600, 8'h00, 16'h0000, 4'b1100, 16'h0000, 2, 1, 0, 0, 8'h01,
                       1, 0, 16'h0000), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
